seg7_char_display: RTL and testbench
====================================

// Module: seg7_char_display
// PURPOSE
//  Display stage directly downstream of the UART character-pair capture stage in rtl/7seg.
//  - Latches the two most recent received characters (char1 = newest, char2 = previous)
//    when the capture stage pulses new_char.
//  - Decodes the two characters to hex glyphs and drives a 4-digit, common-anode
//    7-segment display, time-multiplexed.
//  - Digits 1:0 show char2:char1; digits 3:2 show an 8-bit received-character count in hex.
// PARAMETERS
//  CLK_HZ      100_000_000  clk frequency in Hz
//  DIGIT_HZ    1_000        per-digit dwell rate; PRESC = CLK_HZ/DIGIT_HZ cycles per digit slot (>=4)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst_n     in   1  asynchronous, active-low reset
//  char1     in   8  newest received ASCII character (valid when new_char=1)
//  char2     in   8  previous received ASCII character (valid when new_char=1)
//  new_char  in   1  one-cycle pulse: char1/char2 were just updated (upstream readByte)
//  seg       out  7  segments a..g, active-low, seg[0]=a ... seg[6]=g
//  dp        out  1  decimal point, active-low
//  an        out  4  digit anodes, active-low, an[0] = rightmost digit
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - an=4'b1111, seg=7'h7F, dp=1.
//  - Shadow regs sh1=sh2=8'h20 (space), cnt=0, prescaler=0, digit index=0, state=BLANK.
//  Capture:
//  - On a new_char cycle: sh1<=char1, sh2<=char2, cnt<=cnt+1 (8-bit, 8'hFF wraps to 8'h00).
//  - new_char is accepted in any state; no back-pressure exists.
//  Prescaler:
//  - Counts 0..PRESC-1 and wraps; the wrap cycle is the tick.
//  - Width is $clog2(PRESC).
//  FSM (ghost suppression):
//  - BLANK: an=4'b1111, seg=7'h7F, dp=1 for exactly 2 cycles; then -> DRIVE.
//  - DRIVE: an = one-cold for the current digit index; on tick -> BLANK, and the
//    digit index advances 0->1->2->3->0.
//  Digit sources and glyphs:
//  - Digit sources: d0=sh1, d1=sh2 (ASCII decode); d2=cnt[3:0], d3=cnt[7:4] (nibble decode).
//  - dp is low only on digit 2 (separator); high on all other digits.
//  - ASCII decode: '0'-'9' -> digit glyph; 'A'-'F' and 'a'-'f' -> hex glyph;
//    space -> 7'h7F; any other code -> dash 7'b0111111.
//  - Glyphs (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//    5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011,
//    C=1000110, d=0100001, E=0000110, F=0001110.
//  Output timing:
//  - seg/dp/an are registered.
//  - During DRIVE, seg is recomputed every cycle from the current shadow/cnt values.
//  - A new_char at cycle t shows on the currently driven digit at t+2
//    (shadow update at t+1, output register at t+2).
//  Edge cases:
//  - new_char on the tick cycle: capture still occurs; the FSM transition is unaffected.
//  - Reset asserted mid-scan: outputs blank immediately (asynchronously).
//  - First DRIVE after reset release: digit 0, entered after the 2 BLANK cycles.
// TESTING (CLK_HZ=40, DIGIT_HZ=4 -> PRESC=10)
//  - Reset, release, no input:
//    -> every digit slot shows seg=7'h7F on d0/d1 and '0' glyph 1000000 on d2/d3;
//       dp low on d2 only.
//  - Scan order and ghost suppression:
//    -> an sequence 1110, 1101, 1011, 0111, repeating;
//    -> exactly 2 all-high an cycles between consecutive digits.
//  - Pulse new_char with char1="A", char2="7":
//    -> d0 seg=0001000, d1 seg=1111000, count digits show "01".
//  - Pulse new_char with char1="z", char2=" ":
//    -> d0 dash 0111111, d1 blank 7'h7F.
//  - 256 new_char pulses: cnt wraps to 8'h00 (d3/d2 show "00");
//    new_char held high 3 consecutive cycles -> cnt=3.
//  - Assert rst_n=0 mid-DRIVE on digit 2:
//    -> an=1111 within the same cycle; after release, shadows read space and cnt=0.

Source files
------------

// File: rtl/seg7_char_display.sv
// rtl/seg7_char_display.sv - two-character plus receive-count multiplexed 7-segment display
module seg7_char_display #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char1,
    input  logic [7:0] char2,
    input  logic       new_char,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    // Cycles spent per digit slot, blanking included.
    localparam int PRESC = CLK_HZ / DIGIT_HZ;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Hex nibble to active-low glyph, bit order g..a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // ASCII to glyph: hex digits in either case, space blanks, anything else is a dash.
    function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
        logic [6:0] g;
        logic [7:0] v;
        v = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = c - 8'h30;
            g = hex_glyph(v[3:0]);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            v = c - 8'h37;
            g = hex_glyph(v[3:0]);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            v = c - 8'h57;
            g = hex_glyph(v[3:0]);
        end else if (c == ASCII_SP) begin
            g = SEG_BLANK;
        end else begin
            g = SEG_DASH;
        end
        return g;
    endfunction

    logic [7:0]    sh1_q, sh1_d;
    logic [7:0]    sh2_q, sh2_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    state_t        state_q;
    logic          bcnt_q;
    logic [1:0]    digit_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    an_q;

    logic [6:0]    glyph_cur;
    logic [3:0]    an_cur;

    // Capture next-state: new_char is accepted unconditionally, count wraps naturally.
    always_comb begin
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        cnt_d = cnt_q;
        if (new_char) begin
            sh1_d = char1;
            sh2_d = char2;
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Shadow registers and receive counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1_q <= ASCII_SP;
            sh2_q <= ASCII_SP;
            cnt_q <= 8'h00;
        end else begin
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            cnt_q <= cnt_d;
        end
    end

    // Free-running slot prescaler; the wrap cycle is the slot tick.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Glyph and anode pattern for the digit currently selected by the scan.
    always_comb begin
        case (digit_q)
            2'd0:    glyph_cur = ascii_glyph(sh1_q);
            2'd1:    glyph_cur = ascii_glyph(sh2_q);
            2'd2:    glyph_cur = hex_glyph(cnt_q[3:0]);
            default: glyph_cur = hex_glyph(cnt_q[7:4]);
        endcase
        an_cur = ~(4'b0001 << digit_q);
    end

    // Scan FSM: two blank cycles before every digit to suppress ghosting, outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            bcnt_q  <= 1'b0;
            digit_q <= 2'd0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= 4'b1111;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (bcnt_q) begin
                        state_q <= ST_DRIVE;
                        bcnt_q  <= 1'b0;
                        an_q    <= an_cur;
                        seg_q   <= glyph_cur;
                        dp_q    <= (digit_q != 2'd2);
                    end else begin
                        bcnt_q  <= 1'b1;
                        an_q    <= 4'b1111;
                        seg_q   <= SEG_BLANK;
                        dp_q    <= 1'b1;
                    end
                end
                default: begin
                    if (tick) begin
                        state_q <= ST_BLANK;
                        bcnt_q  <= 1'b0;
                        digit_q <= digit_q + 2'd1;
                        an_q    <= 4'b1111;
                        seg_q   <= SEG_BLANK;
                        dp_q    <= 1'b1;
                    end else begin
                        an_q    <= an_cur;
                        seg_q   <= glyph_cur;
                        dp_q    <= (digit_q != 2'd2);
                    end
                end
            endcase
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_char_display.sv
// tb/tb_seg7_char_display.sv - scoreboard bench for seg7_char_display
module tb_seg7_char_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char1 = 8'h00;
    logic [7:0] char2 = 8'h00;
    logic       new_char = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seg7_char_display #(.CLK_HZ(40), .DIGIT_HZ(4)) dut (
        .clk(clk), .rst_n(rst_n), .char1(char1), .char2(char2),
        .new_char(new_char), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_sh1 = 8'h20;
    logic [7:0] m_sh2 = 8'h20;
    logic [7:0] m_cnt = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int v);
        logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[v];
    endfunction

    function automatic logic [6:0] char_glyph(input logic [7:0] c);
        string up = "0123456789ABCDEF";
        string lo = "0123456789abcdef";
        for (int i = 0; i < 16; i++)
            if (c == up[i] || c == lo[i]) return glyph_of(i);
        if (c == 8'h20) return 7'h7F;
        return 7'h3F;
    endfunction

    // Time reference: edges since reset release; each slot is 10 cycles, first two blank.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // Monitor: scan pattern every cycle, scoreboard glyphs at each slot start.
    always @(negedge clk) begin
        logic [3:0] ea;
        int sl;
        sl = cyc / 10;
        ea = (!rst_n || (cyc % 10) < 2) ? 4'hF : ~(4'b0001 << (sl % 4));
        check("an_scan", {28'h0, an}, {28'h0, ea});
        if (rst_n && (cyc % 10) == 2) begin
            while (sb.size() > 0 && sb[0].slot < sl) begin
                check("slot_missed", sb[0].slot, sl);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].slot == sl) begin
                exp_t e;
                e = sb.pop_front();
                check("an_digit", {28'h0, an}, {28'h0, e.an});
                check("seg", {25'h0, seg}, {25'h0, e.seg});
                check("dp", {31'h0, dp}, {31'h0, e.dp});
            end
        end
    end

    task automatic pulse(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        char1 = a; char2 = b; new_char = 1'b1;
        m_sh1 = a; m_sh2 = b; m_cnt = m_cnt + 8'd1;
        @(negedge clk);
        new_char = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 4))
            0:       return 8'h30 + 8'($urandom_range(0, 9));
            1:       return 8'h41 + 8'($urandom_range(0, 5));
            2:       return 8'h61 + 8'($urandom_range(0, 5));
            3:       return 8'h20;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic burst(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            char1 = rand_char(); char2 = rand_char(); new_char = 1'b1;
            m_sh1 = char1; m_sh2 = char2; m_cnt = m_cnt + 8'd1;
            @(negedge clk);
        end
        new_char = 1'b0;
    endtask

    // Align to a slot boundary and queue the expected contents of the next four slots.
    task automatic commit();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((cyc % 10) != 0 && k < 30);
        check("align_timeout", {31'h0, (k >= 30)}, 32'h0);
        for (int s = 0; s < 4; s++) begin
            exp_t e;
            int d;
            e.slot = cyc / 10 + s;
            d = e.slot % 4;
            e.an = ~(4'b0001 << d);
            e.dp = (d != 2);
            case (d)
                0:       e.seg = char_glyph(m_sh1);
                1:       e.seg = char_glyph(m_sh2);
                2:       e.seg = glyph_of(int'(m_cnt[3:0]));
                default: e.seg = glyph_of(int'(m_cnt[7:4]));
            endcase
            sb.push_back(e);
        end
        repeat (42) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_an", {28'h0, an}, 32'hF);
        check("rst_seg", {25'h0, seg}, 32'h7F);
        check("rst_dp", {31'h0, dp}, 32'h1);
        rst_n = 1'b1;

        commit();
        pulse("A", "7");
        commit();
        pulse("z", " ");
        commit();
        for (int i = 0; i < 8; i++) begin
            pulse(rand_char(), rand_char());
            commit();
        end

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(((cyc / 10) % 4) == 2 && (cyc % 10) == 5) && k < 60);
        check("mid_align_timeout", {31'h0, (k >= 60)}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", {28'h0, an}, 32'hF);
        check("async_seg", {25'h0, seg}, 32'h7F);
        check("async_dp", {31'h0, dp}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_sh1 = 8'h20; m_sh2 = 8'h20; m_cnt = 8'h00;
        commit();

        burst(256);
        commit();
        burst(3);
        commit();
        burst(253);
        commit();

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
